// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;
  localparam int WIDTH = 32;
  localparam int ITERS = 32;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;
endpackage

// File: rtl/negate_thirtytwo_bit.sv
// Conditional two's-complement negate: y = sel ? -x : x.
module negate_thirtytwo_bit
  import mdu_pkg::*;
(
  input  logic             sel,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign y = sel ? (~x + ONE) : x;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle MULTU/MULT/DIVU/DIV unit with HI/LO result registers.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inpA,
  input  logic [WIDTH-1:0] inpB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  import mdu_pkg::*;

  state_e             state, state_nxt;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   bmag, dz_a;
  logic               is_mul, sa, sb, dz_pend;

  logic               accept, dz_req, sgn_op;
  logic [WIDTH-1:0]   amag_in, bmag_in;
  logic [WIDTH:0]     madd, trial;
  logic [WIDTH-1:0]   hi_x, hi_fix, lo_fix;
  logic               lo_zero, hi_sel, lo_sel;

  assign sgn_op = op[0];
  assign accept = start && (state == IDLE);
  assign dz_req = accept && op[1] && (inpB == '0);
  assign busy   = (state != IDLE);

  negate_thirtytwo_bit u_neg_a (.sel(sgn_op & inpA[WIDTH-1]), .x(inpA), .y(amag_in));
  negate_thirtytwo_bit u_neg_b (.sel(sgn_op & inpB[WIDTH-1]), .x(inpB), .y(bmag_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !dz_req) state_nxt = RUN;
      RUN:     if (cnt == 6'(ITERS-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    madd  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : '0);
    trial = acc[2*WIDTH-1:WIDTH-1];
    if (is_mul)
      acc_step = {madd, acc[WIDTH-1:1]};
    else if (trial >= {1'b0, bmag})
      acc_step = {trial[WIDTH-1:0] - bmag, acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // 64-bit product negate split across two 32-bit negators: the high word
  // only takes the +1 carry when the low word is zero.
  assign lo_zero = (acc[WIDTH-1:0] == '0);
  assign lo_sel  = sa ^ sb;
  assign hi_sel  = is_mul ? (lo_sel && lo_zero) : sa;
  assign hi_x    = (is_mul && lo_sel && !lo_zero) ? ~acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  negate_thirtytwo_bit u_neg_hi (.sel(hi_sel), .x(hi_x), .y(hi_fix));
  negate_thirtytwo_bit u_neg_lo (.sel(lo_sel), .x(acc[WIDTH-1:0]), .y(lo_fix));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      bmag        <= '0;
      dz_a        <= '0;
      is_mul      <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      dz_pend     <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done    <= 1'b0;
      dz_pend <= 1'b0;
      // Divide-by-zero completes one edge after acceptance without going busy.
      if (dz_pend) begin
        hi          <= dz_a;
        lo          <= '1;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (dz_req) begin
            dz_pend <= 1'b1;
            dz_a    <= inpA;
          end else if (accept) begin
            acc    <= {{WIDTH{1'b0}}, amag_in};
            bmag   <= bmag_in;
            is_mul <= !op[1];
            sa     <= sgn_op & inpA[WIDTH-1];
            sb     <= sgn_op & inpB[WIDTH-1];
            cnt    <= '0;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          hi          <= hi_fix;
          lo          <= lo_fix;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          cnt         <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule
